bin_to_mask_collector: RTL and testbench
========================================

// Module: bin_to_mask_collector
// PURPOSE
//   Inverse of the 8-to-3 priority encoder. Takes a stream of encoded codes (bin, empty) and
//   decodes each one to one-hot. The one-hot values are OR-accumulated into a pending mask.
//   A frame ends on 'last'; the mask is then offered downstream over a valid/ready handshake.
//   Sits after encoder-driven event sources and rebuilds the set of indices seen in one frame.
// PARAMETERS
//   BIN_W  3  code width; mask width MASK_W = 2**BIN_W (default 8)
//   CNT_W  4  width of the saturating count of non-empty codes per frame
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       synchronous reset, active-high
//   in_valid   in   1       input code valid
//   in_ready   out  1       block can accept a code
//   in_bin     in   BIN_W   encoded index
//   in_empty   in   1       null code: in_bin ignored, no bit set
//   in_last    in   1       code closes the current frame
//   out_valid  out  1       frame result valid
//   out_ready  in   1       downstream accepts frame result
//   out_mask   out  MASK_W  OR of one-hot(in_bin) over non-empty codes of frame
//   out_empty  out  1       out_mask == 0
//   out_count  out  CNT_W   non-empty codes accepted in frame, saturates at 2**CNT_W-1
//   out_dup    out  1       some non-empty code hit an already-set mask bit this frame
// BEHAVIOUR
//   - Reset (synchronous, rst=1 at edge):
//       state=COLLECT, mask=0, count=0, dup=0
//       out_valid=0, in_ready=1, out_mask=0, out_empty=1, out_count=0, out_dup=0
//       Reset overrides all handshakes; a partial frame is discarded.
//   - Input handshake: a code is accepted at an edge where in_valid && in_ready.
//       in_valid may be held without in_ready; inputs must stay stable until accepted.
//   - FSM, 2 states:
//       COLLECT: in_ready=1, out_valid=0.
//         Accepted code with in_empty=0:
//           mask |= (1<<in_bin)
//           dup |= mask[in_bin] (value before the update)
//           count++ (holds at max, no wrap)
//         Accepted code with in_empty=1: mask, count and dup unchanged.
//         Accepted code with in_last=1: fold the code in as above, then go to HOLD.
//       HOLD: in_ready=0, out_valid=1; outputs are registered values, stable until accepted.
//         out_ready=1 at edge: clear mask/count/dup, go to COLLECT.
//         New codes are accepted from the next cycle (one bubble).
//   - Latency: out_valid rises the cycle after the in_last handshake.
//       out_mask includes the last code.
//   - out_empty is derived as ~|out_mask. It is 1 for all-empty or empty+last frames.
//   - Single-code frame (in_last on first code) is legal and gives a one-hot out_mask.
//   - in_bin >= MASK_W is impossible by construction (MASK_W = 2**BIN_W).
//   - out_ready while out_valid=0 is ignored.
//   - No combinational path from out_ready to in_ready.
// TESTING
//   1. Reset: rst=1 for 2 cycles.
//      -> out_valid=0, in_ready=1, out_mask=0, out_empty=1, out_count=0.
//   2. Codes 3, 5, 0 (last on 0), out_ready=1.
//      -> out_mask=8'h29, count=3, dup=0.
//      -> out_valid high exactly 1 cycle after the last handshake.
//   3. Codes 7, 7, empty+last.
//      -> out_mask=8'h80, count=2, dup=1, out_empty=0.
//   4. Frame of only empty codes with last.
//      -> out_mask=0, out_empty=1, count=0.
//   5. Backpressure: hold out_ready=0 for 5 cycles after a frame.
//      -> in_ready=0 and outputs stable throughout.
//      -> after out_ready=1, next frame starts clean with mask=0.
//   6. Saturation and reset: 20 non-empty codes in one frame (CNT_W=4).
//      -> count=15.
//      Separately, assert rst mid-frame after codes 1, 2, then send code 4+last.
//      -> out_mask=8'h10, count=1.

Source files
------------

// File: rtl/bin_to_mask_collector.sv
// Decodes a stream of encoded indices to one-hot and OR-accumulates them per frame; the frame
// result (mask, count, duplicate flag) is offered over valid/ready one cycle after the last code.
module bin_to_mask_collector #(
    parameter int BIN_W  = 3,
    parameter int CNT_W  = 4,
    localparam int MASK_W = 2**BIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIN_W-1:0]  in_bin,
    input  logic              in_empty,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MASK_W-1:0] out_mask,
    output logic              out_empty,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_dup
);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q;
    logic [MASK_W-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dup_q, dup_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [MASK_W-1:0]  onehot;

    // Frame state with the currently presented code folded in; only committed on a handshake.
    always_comb begin
        onehot = MASK_W'(1) << in_bin;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        dup_d  = dup_q;
        if (!in_empty) begin
            mask_d = mask_q | onehot;
            dup_d  = dup_q | mask_q[in_bin];
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            mask_q      <= '0;
            cnt_q       <= '0;
            dup_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        mask_q <= mask_d;
                        cnt_q  <= cnt_d;
                        dup_q  <= dup_d;
                        if (in_last) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Clearing here costs one bubble before the next frame's first code.
                    if (out_ready) begin
                        state_q     <= COLLECT;
                        mask_q      <= '0;
                        cnt_q       <= '0;
                        dup_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_mask  = mask_q;
    assign out_empty = ~|mask_q;
    assign out_count = cnt_q;
    assign out_dup   = dup_q;

endmodule

// File: tb/tb_bin_to_mask_collector.sv
// Bench for bin_to_mask_collector: directed scenarios plus random frames against a set-based model.
module tb_bin_to_mask_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_empty, in_last;
    logic [2:0] in_bin;
    logic       out_valid, out_ready, out_empty, out_dup;
    logic [7:0] out_mask;
    logic [3:0] out_count;

    int vecs = 0;
    int errs = 0;
    int frame[$];   // codes of the frame in progress; -1 marks an empty code

    always #5 clk = ~clk;

    bin_to_mask_collector #(.BIN_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .in_empty(in_empty), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
        .out_empty(out_empty), .out_count(out_count), .out_dup(out_dup)
    );

    // Expected frame result: the set of indices seen, how many real codes, any repeat.
    function automatic void model(output logic [7:0] m, output logic [3:0] c, output logic d);
        int n;
        m = 8'h00; d = 1'b0; n = 0;
        foreach (frame[i]) begin
            if (frame[i] >= 0) begin
                if (m[frame[i]]) d = 1'b1;
                m[frame[i]] = 1'b1;
                n++;
            end
        end
        c = (n > 15) ? 4'd15 : 4'(n);
    endfunction

    task automatic send(input int code, input bit last);
        in_valid = 1'b1;
        in_empty = (code < 0);
        in_bin   = (code < 0) ? 3'($urandom_range(0, 7)) : 3'(code);
        in_last  = last;
        for (int t = 0; t < 100 && !in_ready; t++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            vecs++; errs++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        frame.push_back(code);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        frame.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_bin = '0; in_empty = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vecs++;
        if ({out_valid, in_ready, out_mask, out_empty, out_count, out_dup} !== {1'b0, 1'b1, 8'h00, 1'b1, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset: valid=%0b rdy=%0b mask=%h empty=%0b cnt=%0d dup=%0b required 0 1 00 1 0 0",
                     out_valid, in_ready, out_mask, out_empty, out_count, out_dup);
        end
    endtask

    task automatic test_basic();
        send(3, 0); send(5, 0);
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL basic_early_valid: out_valid=%0b required 0", out_valid);
        end
        send(0, 1);
        vecs++;
        if ({out_valid, out_mask, out_count, out_dup, out_empty} !== {1'b1, 8'h29, 4'd3, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL basic: valid=%0b mask=%h cnt=%0d dup=%0b empty=%0b required 1 29 3 0 0",
                     out_valid, out_mask, out_count, out_dup, out_empty);
        end
        drain();
        vecs++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errs++; $display("FAIL basic_release: rdy=%0b valid=%0b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_dup();
        send(7, 0); send(7, 0); send(-1, 1);
        vecs++;
        if ({out_valid, out_mask, out_count, out_dup, out_empty} !== {1'b1, 8'h80, 4'd2, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL dup: valid=%0b mask=%h cnt=%0d dup=%0b empty=%0b required 1 80 2 1 0",
                     out_valid, out_mask, out_count, out_dup, out_empty);
        end
        drain();
    endtask

    task automatic test_all_empty();
        send(-1, 0); send(-1, 0); send(-1, 1);
        vecs++;
        if ({out_valid, out_mask, out_empty, out_count, out_dup} !== {1'b1, 8'h00, 1'b1, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL all_empty: valid=%0b mask=%h empty=%0b cnt=%0d dup=%0b required 1 00 1 0 0",
                     out_valid, out_mask, out_empty, out_count, out_dup);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] m; logic [3:0] c; logic d;
        send(1, 0); send(6, 1);
        model(m, c, d);
        // A code is left pending on the input; it must not be absorbed while HOLD.
        in_valid = 1'b1; in_bin = 3'd4; in_empty = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vecs++;
            if ({in_ready, out_valid, out_mask, out_count, out_dup} !== {1'b0, 1'b1, m, c, d}) begin
                errs++;
                $display("FAIL backpressure_cycle%0d: rdy=%0b valid=%0b mask=%h cnt=%0d dup=%0b required 0 1 %h %0d %0b",
                         i, in_ready, out_valid, out_mask, out_count, out_dup, m, c, d);
            end
        end
        in_valid = 1'b0;
        drain();
        send(2, 1);
        vecs++;
        if ({out_mask, out_count, out_dup} !== {8'h04, 4'd1, 1'b0}) begin
            errs++;
            $display("FAIL backpressure_clean: mask=%h cnt=%0d dup=%0b required 04 1 0", out_mask, out_count, out_dup);
        end
        drain();
    endtask

    task automatic test_saturation_and_reset();
        logic [7:0] m; logic [3:0] c; logic d;
        for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 7)), i == 19);
        model(m, c, d);
        vecs++;
        if ({out_count, out_mask, out_dup} !== {4'd15, m, d}) begin
            errs++;
            $display("FAIL saturation: cnt=%0d mask=%h dup=%0b required 15 %h %0b", out_count, out_mask, out_dup, m, d);
        end
        drain();
        send(1, 0); send(2, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        frame.delete();
        send(4, 1);
        vecs++;
        if ({out_valid, out_mask, out_count, out_dup} !== {1'b1, 8'h10, 4'd1, 1'b0}) begin
            errs++;
            $display("FAIL midframe_reset: valid=%0b mask=%h cnt=%0d dup=%0b required 1 10 1 0",
                     out_valid, out_mask, out_count, out_dup);
        end
        drain();
    endtask

    task automatic test_random_frames();
        logic [7:0] m; logic [3:0] c; logic d;
        int len;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 7)), k == len - 1);
            end
            model(m, c, d);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            vecs++;
            if ({out_valid, out_mask, out_empty, out_count, out_dup} !== {1'b1, m, (m == 8'h00), c, d}) begin
                errs++;
                $display("FAIL random_frame%0d: valid=%0b mask=%h empty=%0b cnt=%0d dup=%0b required 1 %h %0b %0d %0b",
                         f, out_valid, out_mask, out_empty, out_count, out_dup, m, (m == 8'h00), c, d);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dup();
        test_all_empty();
        test_backpressure();
        test_saturation_and_reset();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
